morse_key_timer: RTL

Front-end timing classifier for the Morse path. It takes the raw, asynchronous key/button level and synchronizes and debounces it. It then measures press and gap durations in clock cycles and emits the single-cycle `dot`, `dash`, `char_end` and `word_end` pulses consumed directly by `morse_decoder`. All thresholds are parameters in clock cycles, so the board clock rate only affects the chosen values.

---
 rtl/morse_key_timer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/morse_key_timer.sv
// Morse key front end: synchronizes and debounces a raw key, then classifies
// press/gap durations into single-cycle dot, dash, char_end and word_end pulses.
module morse_key_timer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DOT_MAX_CYCLES  = 10000000,
  parameter int unsigned CHAR_GAP_CYCLES = 20000000,
  parameter int unsigned WORD_GAP_CYCLES = 50000000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic dot,
  output logic dash,
  output logic char_end,
  output logic word_end,
  output logic key_db,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    WORD_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(CHAR_GAP_CYCLES);
  localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(WORD_GAP_CYCLES);

  logic             s1_q, key_s_q;
  logic             key_db_q, key_db_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] gap_inc;
  logic             dot_q, dot_d;
  logic             dash_q, dash_d;
  logic             char_end_q, char_end_d;
  logic             word_end_q, word_end_d;

  // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive differing samples.
  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    db_cnt_d = db_cnt_q;
    key_db_d = key_db_q;
    if (key_s_q == key_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      key_db_d = ~key_db_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CNT_ONE;
    end
  end

  assign gap_inc = gap_cnt_q + CNT_ONE;

  // A rising key_db is checked before any gap threshold, so a re-press wins over a gap pulse.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    dot_d       = 1'b0;
    dash_d      = 1'b0;
    char_end_d  = 1'b0;
    word_end_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_db_q) begin
          state_d     = PRESS;
          press_cnt_d = CNT_ONE;
        end
      end
      PRESS: begin
        if (key_db_q) begin
          if (press_cnt_q != CNT_MAX) press_cnt_d = press_cnt_q + CNT_ONE;
        end else begin
          if (press_cnt_q <= DOT_MAX) dot_d = 1'b1;
          else                        dash_d = 1'b1;
          state_d   = GAP;
          gap_cnt_d = CNT_ONE;
        end
      end
      GAP: begin
        if (key_db_q) begin
          state_d     = PRESS;
          press_cnt_d = CNT_ONE;
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == CHAR_GAP) begin
            char_end_d = 1'b1;
            state_d    = WORD_WAIT;
          end
        end
      end
      WORD_WAIT: begin
        if (key_db_q) begin
          state_d     = PRESS;
          press_cnt_d = CNT_ONE;
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == WORD_GAP) begin
            word_end_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      key_s_q     <= 1'b0;
      key_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      dot_q       <= 1'b0;
      dash_q      <= 1'b0;
      char_end_q  <= 1'b0;
      word_end_q  <= 1'b0;
    end else begin
      s1_q        <= key_in;
      key_s_q     <= s1_q;
      key_db_q    <= key_db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dot_q       <= dot_d;
      dash_q      <= dash_d;
      char_end_q  <= char_end_d;
      word_end_q  <= word_end_d;
    end
  end

  assign dot      = dot_q;
  assign dash     = dash_q;
  assign char_end = char_end_q;
  assign word_end = word_end_q;
  assign key_db   = key_db_q;
  assign busy     = (state_q != IDLE);

endmodule
